mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with registered read.
// Each access is latched in IDLE, issued for one cycle, and reads spend one extra cycle in READ.
module mem_arbiter #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          mem_we,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_data_in,
   input  logic [DW-1:0] mem_data_out
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] READ  = 2'd2;

   logic [1:0]    state;
   logic          owner;
   logic          last_gnt;
   logic          lat_we;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic          win;

   // A tie goes to whoever was not served last; a lone requester always wins.
   assign win = (req0 && req1) ? ~last_gnt : req1;

   // The latched registers only change on a grant, so the memory bus holds its last values.
   assign mem_address = lat_addr;
   assign mem_data_in = lat_wdata;
   assign mem_we      = (state == ISSUE) && lat_we;
   assign gnt0        = (state == ISSUE) && !owner;
   assign gnt1        = (state == ISSUE) && owner;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= 1'b0;
         last_gnt  <= 1'b1;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata     <= '0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
      end else begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner     <= win;
                  last_gnt  <= win;
                  lat_we    <= win ? we1 : we0;
                  lat_addr  <= win ? addr1 : addr0;
                  lat_wdata <= win ? wdata1 : wdata0;
                  state     <= ISSUE;
               end
            end
            ISSUE: state <= lat_we ? IDLE : READ;
            READ: begin
               // Memory output became valid this cycle, one edge after the address was issued.
               rdata   <= mem_data_out;
               rvalid0 <= ~owner;
               rvalid1 <= owner;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
